// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: 32-bit memory-stage port onto a 16-bit async SRAM.
// Optional one-word load bypass buffer: `define SRAM_READ_BYPASS_EN.
module mem_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic [2:0]  WC   = 3'(WAIT_CYCLES);
  localparam logic [31:0] BASE = 32'(BASE_ADDR);

  state_t      state;
  state_t      state_d;
  logic [2:0]  cnt;
  logic [2:0]  cnt_d;
  logic        op_wr;
  logic [16:0] w_q;
  logic [31:0] wdata_q;
  logic [31:0] off;
  logic [16:0] w_in;
  logic        req;
  logic        last;
  logic        start;
  logic        hit;
  logic        unused_off;

  assign off        = address - BASE;
  assign w_in       = off[18:2];
  assign unused_off = ^{off[31:19], off[1:0]};
  assign req        = mem_read | mem_write;
  assign last       = (cnt == WC);
  assign start      = (state == IDLE) && req && !hit;

`ifdef SRAM_READ_BYPASS_EN
  logic        byp_v;
  logic [16:0] byp_w;
  logic [31:0] byp_d;

  assign hit = (state == IDLE) && mem_read && !mem_write
            && byp_v && (byp_w == w_in);

  // Capture finished loads; keep buffer coherent with finished stores
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byp_v <= 1'b0;
      byp_w <= '0;
      byp_d <= '0;
    end else if (state == DONE) begin
      if (!op_wr) begin
        byp_v <= 1'b1;
        byp_w <= w_q;
        byp_d <= read_data;
      end else if (byp_v && (byp_w == w_q)) begin
        byp_d <= wdata_q;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  // State and phase counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state: each phase lasts WAIT_CYCLES+1 cycles
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = LO;
          cnt_d   = '0;
        end
      end
      LO: begin
        if (last) begin
          state_d = HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 3'd1;
        end
      end
      HI: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 3'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch op type, word index and store data when an access starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr   <= 1'b0;
      w_q     <= '0;
      wdata_q <= '0;
    end else if (start) begin
      op_wr   <= mem_write;
      w_q     <= w_in;
      wdata_q <= write_data;
    end
  end

  // Load result: one half per phase, or whole word from the buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else if ((state == LO) && last && !op_wr) begin
      read_data[15:0] <= sram_dq_in;
    end else if ((state == HI) && last && !op_wr) begin
      read_data[31:16] <= sram_dq_in;
`ifdef SRAM_READ_BYPASS_EN
    end else if (hit) begin
      read_data <= byp_d;
`endif
    end
  end

  assign sram_addr   = {w_q, (state == HI)};
  assign sram_dq_out = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];

  // SRAM strobes and pipeline handshake
  always_comb begin
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_dq_oe = 1'b0;
    ready      = 1'b0;
    unique case (1'b1)
      (state == LO), (state == HI): begin
        sram_we_n  = !op_wr;
        sram_oe_n  = op_wr;
        sram_dq_oe = op_wr;
      end
      (state == DONE): ready = 1'b1;
      default: ready = !req || hit;
    endcase
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: scoreboard bench for mem_sram_ctrl.
// Bypass checks enabled with `define SRAM_READ_BYPASS_EN.
module tb_mem_sram_ctrl;

  localparam int PH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_done = 0;

  logic [15:0] sram [0:255];
  logic [31:0] shadow [int];
  logic [31:0] exp_q [$];
  logic [31:0] exp_rd;

  mem_sram_ctrl #(
    .WAIT_CYCLES(1),
    .BASE_ADDR(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address(address),
    .write_data(write_data),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .read_data(read_data),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) sram[sram_addr[7:0]] <= sram_dq_out;

  assign sram_dq_in = sram_oe_n ? 16'h0 : sram[sram_addr[7:0]];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d,
                        input logic rd, input logic wr,
                        input logic keep);
    logic [31:0] off;
    logic [16:0] w;
    logic        hi;
    off = a - 32'd1024;
    w = off[18:2];
    address = a;
    write_data = d;
    mem_read = rd;
    mem_write = wr;
    if (wr) shadow[int'(w)] = d;
    else exp_q.push_back(shadow.exists(int'(w)) ? shadow[int'(w)] : 32'h0);
    #1;
    chk("req_rdy", 32'(ready), 32'd0);
    for (int k = 1; k <= 2*PH+1; k++) begin
      @(posedge clk);
      #1;
      if (k <= 2*PH) begin
        hi = (k > PH);
        chk("busy_rdy", 32'(ready), 32'd0);
        chk("addr", 32'(sram_addr), 32'({w, hi}));
        chk("we_n", 32'(sram_we_n), 32'(!wr));
        chk("oe_n", 32'(sram_oe_n), 32'(wr));
        chk("dq_oe", 32'(sram_dq_oe), 32'(wr));
        if (wr) chk("dq_out", 32'(sram_dq_out), 32'(hi ? d[31:16] : d[15:0]));
      end else begin
        last_done = cyc;
        chk("done_rdy", 32'(ready), 32'd1);
        chk("done_we_n", 32'(sram_we_n), 32'd1);
        chk("done_oe_n", 32'(sram_oe_n), 32'd1);
        if (!wr) exp_rd = exp_q.pop_front();
        chk("rdata", read_data, exp_rd);
      end
    end
    if (!keep) begin
      mem_read = 1'b0;
      mem_write = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("idle_rdy", 32'(ready), keep ? 32'd0 : 32'd1);
    chk("hold", read_data, exp_rd);
  endtask

`ifdef SRAM_READ_BYPASS_EN
  task automatic byp_load(input logic [31:0] a, input logic [31:0] e);
    address = a;
    mem_read = 1'b1;
    mem_write = 1'b0;
    exp_q.push_back(e);
    #1;
    chk("byp_rdy", 32'(ready), 32'd1);
    chk("byp_oe_n", 32'(sram_oe_n), 32'd1);
    @(posedge clk);
    #1;
    exp_rd = exp_q.pop_front();
    chk("byp_rdata", read_data, exp_rd);
    chk("byp_oe_n2", 32'(sram_oe_n), 32'd1);
    chk("byp_we_n", 32'(sram_we_n), 32'd1);
    mem_read = 1'b0;
  endtask
`else
  int d1;
`endif

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 16'h0;
    rst = 1'b0;
    address = 32'd1028;
    write_data = 32'hDEADBEEF;
    mem_read = 1'b0;
    mem_write = 1'b1;
    exp_rd = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq", 32'(sram_dq_out), 32'h0);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_rdy", 32'(ready), 32'd0);
    rst = 1'b1;

    access(32'd1028, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    access(32'd1028, 32'h0, 1'b1, 1'b0, 1'b0);

`ifdef SRAM_READ_BYPASS_EN
    byp_load(32'd1028, 32'hDEADBEEF);
    access(32'd1028, 32'h12345678, 1'b0, 1'b1, 1'b0);
    byp_load(32'd1028, 32'h12345678);
    access(32'd1032, 32'h0, 1'b1, 1'b0, 1'b0);
`else
    access(32'd1040, 32'h0BADF00D, 1'b0, 1'b1, 1'b0);
    access(32'd1040, 32'h0, 1'b1, 1'b0, 1'b1);
    d1 = last_done;
    access(32'd1040, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("b2b_gap", 32'(last_done - d1), 32'd6);
`endif

    access(32'd1044, 32'hCAFE1234, 1'b1, 1'b1, 1'b0);
    access(32'd1044, 32'h0, 1'b1, 1'b0, 1'b0);

    address = 32'd1028;
    mem_read = 1'b1;
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
    chk("abort_addr", 32'(sram_addr), 32'h0);
    chk("abort_rdata", read_data, 32'h0);
    chk("abort_rdy", 32'(ready), 32'd0);
    mem_read = 1'b0;
    exp_rd = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    access(32'd1028, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

Multi-cycle controller between the memory stage and an external 16-bit asynchronous SRAM; it replaces the single-cycle data memory behind the memory stage. It takes the memory stage's address (ALU result), store data (Rm value) and read/write strobes. It splits each 32-bit access into two 16-bit SRAM phases and returns the load word toward the memory/write-back pipeline register. While an access is in flight, `ready` is low, and the hazard/freeze logic holds every pipeline register.

## Interface
Parameters:
- `WAIT_CYCLES`, default 1: extra cycles each SRAM phase is held (phase length = WAIT_CYCLES+1 cycles); legal range 0..7.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1: clock; all state changes on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `address`  in  32: byte address from the memory stage (ALU result).
- `write_data`  in  32: store data (Rm value).
- `mem_read`  in  1: load request, level-sensitive.
- `mem_write`  in  1: store request, level-sensitive.
- `read_data`  out  32: load result, registered.
- `ready`  out  1: high when no access is pending or the current access completes this cycle.
- `sram_addr`  out  18: SRAM halfword address.
- `sram_dq_out`  out  16: SRAM write data.
- `sram_dq_in`  in  16: SRAM read data.
- `sram_dq_oe`  out  1: drive enable for the DQ bus (board top builds the tristate).
- `sram_we_n`  out  1: SRAM write enable, active-low.
- `sram_oe_n`  out  1: SRAM output enable, active-low.

## Operation
- Word index `w` = (`address` − BASE_ADDR) mod 2^32, bits [18:2]. Low halfword is at SRAM {w,0}; high halfword is at {w,1}. Bits [1:0] are ignored.
- FSM states: IDLE, LO, HI, DONE. A 3-bit phase counter runs inside LO and HI.
- IDLE:
  - `mem_write` → LO (write).
  - Else `mem_read` → LO (read).
  - Else stay. Write wins if both strobes are high.
  - Op type and `w` are latched on entry to LO.
- LO/HI:
  - Hold `sram_addr` for WAIT_CYCLES+1 cycles, then advance (LO→HI→DONE).
  - Write: `sram_we_n`=0, `sram_oe_n`=1, `sram_dq_oe`=1; `sram_dq_out` = write_data[15:0] in LO, [31:16] in HI.
  - Read: `sram_we_n`=1, `sram_oe_n`=0, `sram_dq_oe`=0. `sram_dq_in` is sampled on the last cycle of each phase into read_data[15:0] (LO) and [31:16] (HI).
- DONE: one cycle; SRAM strobes inactive; `ready`=1; → IDLE unconditionally.
- `ready` (combinational):
  - 1 in DONE, or in IDLE with no request.
  - 0 in IDLE with a request, and in LO/HI.
  - Bypass-hit exception: see Configuration.
- A request still asserted in IDLE right after DONE is a new instruction; it starts a new access.
- `read_data` holds its value between loads. Stores never change it, except for a bypass-buffer update.

## Timing
- Reset values: `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, `sram_oe_n`=1, state IDLE, counter 0, bypass buffer invalid.
- `ready` after reset is 1 if no request is present.
- Latency, request seen in IDLE to `ready`=1: 2·(WAIT_CYCLES+1)+1 cycles. With default WAIT_CYCLES=1 this is 5 cycles (IDLE, LO×2, HI×2) with `ready` high in the 6th (DONE) cycle.
- Load data is valid in `read_data` during DONE. The pipeline captures it on the DONE→IDLE edge.
- Requests must stay stable while `ready`=0; the frozen pipeline guarantees this. Changes during LO/HI are ignored because op type and `w` are latched.
- Reset asserted mid-access aborts immediately: outputs take their reset values asynchronously, and a half-written word stays partially written.
- WAIT_CYCLES=0: each phase is 1 cycle; latency is 3 cycles.

## Configuration
- `SRAM_READ_BYPASS_EN` defined:
  - A one-entry buffer holds {valid, w, data} of the last completed load.
  - A load in IDLE whose `w` matches a valid entry completes in the same cycle: `ready`=1, and `read_data` is loaded from the buffer at the clock edge. No SRAM cycle occurs; the FSM stays in IDLE.
  - A completed store to the buffered `w` overwrites the buffered data with `write_data`.
  - Reset invalidates the buffer.
- Not defined: no buffer; every load takes the full FSM path.

## Test plan
- Reset with `rst`=0 while a request is asserted → all outputs at reset values and `ready`=0; release → LO entered on the next edge.
- Store 0xDEADBEEF to address 1028 (WAIT_CYCLES=1):
  - `sram_addr`=2 for 2 cycles with dq 0xBEEF, then 3 for 2 cycles with 0xDEAD.
  - `sram_we_n`=0 throughout both phases; `ready`=1 in cycle 5.
- Load from 1028, with a SRAM model returning stored halves → `read_data`=0xDEADBEEF in DONE; `sram_oe_n`=0 for 4 cycles; `read_data` unchanged afterwards with no request.
- Load, then load back-to-back with `mem_read` held through DONE → a second full access starts; two separate DONE pulses 6 cycles apart.
- `mem_read`=`mem_write`=1 → store performed, `read_data` unchanged.
- With `SRAM_READ_BYPASS_EN`:
  - Repeat load of 1028 → `ready`=1 in the same cycle and no SRAM strobe.
  - Store 0x12345678 to 1028, then load → 0x12345678 with zero wait.
  - Load 1032 → full 5-cycle access.
